// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and busy-update priority kinds for the register file
package regfile_pkg;
    localparam int REG_ZERO  = 0;
    localparam int DEF_N     = 32;
    localparam int DEF_DEPTH = 32;
    typedef enum logic [1:0] {SB_FLUSH, SB_ISSUE, SB_CLEAR} sb_prio_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with flush/issue/clear priority and pending count
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          flush,
    output logic          rd_busy1,
    output logic          rd_busy2,
    output logic [AW:0]   pend_cnt
);
    logic [DEPTH-1:0] busy, busy_nxt;
    logic [AW:0]      cnt;
    always_comb begin
        busy_nxt = busy;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_nxt[i] = (ZERO_REG != 0 && i == REG_ZERO) ? 1'b0 :
                          flush                            ? 1'b0 :
                          (iss_en && iss_addr == AW'(i))   ? 1'b1 :
                          (wr_en && wr_addr == AW'(i))     ? 1'b0 : busy[i];
            cnt = cnt + (AW+1)'(busy_nxt[i]);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt;
        end
    end
    // A writeback seen this cycle already releases the operand when it is forwarded
    assign rd_busy1 = busy[rd_addr1] & ~(BYPASS != 0 && wr_en && wr_addr == rd_addr1);
    assign rd_busy2 = busy[rd_addr2] & ~(BYPASS != 0 && wr_en && wr_addr == rd_addr2);
endmodule

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: 2-read/1-write register file with write-to-read bypass,
// busy scoreboard and RAW stall request
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    input  logic          rd_use1,
    input  logic          rd_use2,
    output logic [N-1:0]  rd_data1,
    output logic [N-1:0]  rd_data2,
    output logic          rd_busy1,
    output logic          rd_busy2,
    output logic          stall,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          flush,
    output logic [AW:0]   pend_cnt
);
    logic [N-1:0] regs [DEPTH];
    logic         zero1, zero2, zero_wr, fwd1, fwd2;
    assign zero1   = ZERO_REG != 0 && rd_addr1 == AW'(REG_ZERO);
    assign zero2   = ZERO_REG != 0 && rd_addr2 == AW'(REG_ZERO);
    assign zero_wr = ZERO_REG != 0 && wr_addr == AW'(REG_ZERO);
    assign fwd1    = BYPASS != 0 && wr_en && wr_addr == rd_addr1;
    assign fwd2    = BYPASS != 0 && wr_en && wr_addr == rd_addr2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en && !zero_wr) begin
            regs[wr_addr] <= wr_data;
        end
    end
    assign rd_data1 = zero1 ? '0 : fwd1 ? wr_data : regs[rd_addr1];
    assign rd_data2 = zero2 ? '0 : fwd2 ? wr_data : regs[rd_addr2];
    assign stall    = (rd_use1 & rd_busy1) | (rd_use2 & rd_busy2);
    regfile_scoreboard #(
        .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_sb (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .flush(flush), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2), .pend_cnt(pend_cnt)
    );
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: scoreboard bench driving two builds (32x32 zero-reg+bypass,
// 16x64 plain) from one stimulus stream against an array-based reference model
module tb_regfile_bypass_sb;
    import regfile_pkg::*;
    typedef struct packed {
        logic [63:0] d1, d2;
        logic        b1, b2, st;
        logic [5:0]  pc;
    } obs_t;
    logic        clk = 1'b0, rst = 1'b0;
    logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, iss_addr = '0, wr_addr = '0;
    logic        rd_use1 = 1'b0, rd_use2 = 1'b0, iss_en = 1'b0, wr_en = 1'b0, flush = 1'b0;
    logic [63:0] wr_data = '0;
    logic [31:0] a_d1, a_d2;
    logic        a_b1, a_b2, a_st;
    logic [5:0]  a_pc;
    logic [63:0] b_d1, b_d2;
    logic        b_b1, b_b2, b_st;
    logic [4:0]  b_pc;
    int          checks = 0, errors = 0, cyc = 0;
    obs_t        q0[$], q1[$];
    int          dep[2] = '{32, 16};
    bit          zr[2]  = '{1'b1, 1'b0};
    bit          byp[2] = '{1'b1, 1'b0};
    int          nw[2]  = '{32, 64};
    logic [63:0] mem[2][32];
    bit          bz[2][32];

    always #5 clk = ~clk;

    regfile_bypass_sb #(.N(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_use1(rd_use1), .rd_use2(rd_use2), .rd_data1(a_d1), .rd_data2(a_d2),
        .rd_busy1(a_b1), .rd_busy2(a_b2), .stall(a_st), .iss_en(iss_en),
        .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[31:0]),
        .flush(flush), .pend_cnt(a_pc)
    );
    regfile_bypass_sb #(.N(64), .DEPTH(16), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1[3:0]), .rd_addr2(rd_addr2[3:0]),
        .rd_use1(rd_use1), .rd_use2(rd_use2), .rd_data1(b_d1), .rd_data2(b_d2),
        .rd_busy1(b_b1), .rd_busy2(b_b2), .stall(b_st), .iss_en(iss_en),
        .iss_addr(iss_addr[3:0]), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
        .flush(flush), .pend_cnt(b_pc)
    );

    function automatic logic [63:0] msk(int k, logic [63:0] v);
        return nw[k] == 64 ? v : (v & 64'hFFFF_FFFF);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                mem[k][r] = '0;
                bz[k][r]  = 1'b0;
            end
    endfunction

    // Register state advances once per rising edge using the inputs held across it
    function automatic void model_edge();
        if (!rst) return;
        for (int k = 0; k < 2; k++) begin
            int w  = int'(wr_addr) % dep[k];
            int ia = int'(iss_addr) % dep[k];
            if (flush) begin
                for (int r = 0; r < 32; r++) bz[k][r] = 1'b0;
            end else begin
                if (wr_en) bz[k][w] = 1'b0;
                if (iss_en) bz[k][ia] = 1'b1;
            end
            if (wr_en) mem[k][w] = msk(k, wr_data);
            if (zr[k]) begin
                mem[k][REG_ZERO] = '0;
                bz[k][REG_ZERO]  = 1'b0;
            end
        end
    endfunction

    function automatic void model_read(int k, int a, output logic [63:0] d, output logic b);
        int  x   = a % dep[k];
        bit  z   = zr[k] && x == REG_ZERO;
        bit  fwd = byp[k] && wr_en && (int'(wr_addr) % dep[k]) == x && !z;
        d = z ? 64'h0 : fwd ? msk(k, wr_data) : mem[k][x];
        b = !z && bz[k][x] && !fwd;
    endfunction

    function automatic obs_t expect_obs(int k);
        obs_t o;
        int   n = 0;
        model_read(k, int'(rd_addr1), o.d1, o.b1);
        model_read(k, int'(rd_addr2), o.d2, o.b2);
        o.st = (rd_use1 && o.b1) || (rd_use2 && o.b2);
        for (int r = 0; r < dep[k]; r++) n += int'(bz[k][r]);
        o.pc = 6'(n);
        return o;
    endfunction

    task automatic step(input bit we, input int wa, input logic [63:0] wd, input bit ie,
                        input int ia, input bit fl, input int a1, input int a2,
                        input bit u1, input bit u2, input bit r);
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        wr_en = we; wr_addr = 5'(wa); wr_data = wd;
        iss_en = ie; iss_addr = 5'(ia); flush = fl;
        rd_addr1 = 5'(a1); rd_addr2 = 5'(a2); rd_use1 = u1; rd_use2 = u2;
        rst = r;
        if (!r) model_reset();
        q0.push_back(expect_obs(0));
        q1.push_back(expect_obs(1));
    endtask

    task automatic idle_read(input int a1, input int a2);
        step(0, 0, 0, 0, 0, 0, a1, a2, 1, 1, 1);
    endtask

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s inst%0d cycle %0d actual %h required %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic cmp(input int k, input obs_t a, input obs_t e);
        chk("rd_data1", k, a.d1, e.d1);
        chk("rd_data2", k, a.d2, e.d2);
        chk("rd_busy1", k, 64'(a.b1), 64'(e.b1));
        chk("rd_busy2", k, 64'(a.b2), 64'(e.b2));
        chk("stall", k, 64'(a.st), 64'(e.st));
        chk("pend_cnt", k, 64'(a.pc), 64'(e.pc));
    endtask

    initial begin
        obs_t a;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                a.d1 = {32'h0, a_d1}; a.d2 = {32'h0, a_d2};
                a.b1 = a_b1; a.b2 = a_b2; a.st = a_st; a.pc = a_pc;
                cmp(0, a, q0.pop_front());
            end
            if (q1.size() > 0) begin
                a.d1 = b_d1; a.d2 = b_d2;
                a.b1 = b_b1; a.b2 = b_b2; a.st = b_st; a.pc = {1'b0, b_pc};
                cmp(1, a, q1.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) idle_read(i, 31 - i);
        // same-cycle write forwarding, then array read
        step(1, 5, 64'hDEADBEEF, 0, 0, 0, 5, 5, 1, 1, 1);
        idle_read(5, 5);
        // register 0 writes and issues
        step(1, 0, 64'h1234, 0, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        idle_read(0, 0);
        // RAW hazard on r7 released by writeback
        step(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1);
        idle_read(7, 1);
        step(1, 7, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 7, 7, 1, 0, 1);
        idle_read(7, 7);
        // issue beats writeback; flush drops everything and ignores issue
        step(1, 3, 64'h33, 1, 3, 0, 3, 3, 1, 1, 1);
        idle_read(3, 3);
        step(0, 0, 0, 1, 9, 1, 3, 9, 1, 1, 1);
        idle_read(3, 9);
        // mid-operation reset
        for (int i = 1; i <= 4; i++) step(1, i + 10, 64'(i) * 64'h1111, 1, i, 0, i, i + 10, 1, 1, 1);
        idle_read(2, 12);
        step(0, 0, 0, 0, 0, 0, 2, 12, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 3, 13, 1, 1, 1);
        idle_read(4, 14);
        for (int n = 0; n < 2500; n++) begin
            sb_prio_e m = sb_prio_e'($urandom_range(0, 2));
            int  wa = $urandom_range(0, 31);
            int  ia = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            int  a1 = ($urandom_range(0, 2) == 0) ? wa : ($urandom_range(0, 2) == 0) ? ia : $urandom_range(0, 31);
            int  a2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            bit  fl = (m == SB_FLUSH) && ($urandom_range(0, 3) == 0);
            bit  ie = (m == SB_ISSUE) || ($urandom_range(0, 3) == 0);
            bit  we = (m == SB_CLEAR) || ($urandom_range(0, 2) == 0);
            bit  r  = $urandom_range(0, 199) != 0;
            step(we, wa, {$urandom, $urandom}, ie, ia, fl, a1, a2,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
        end
        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual %0d/%0d pending required 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
